// File: rtl/shim_threshold_integrator_n.sv
// shim_threshold_integrator_n
// Rolling-window threshold integrator for the shim channel-monitoring path.
// Decimated absolute-value samples of N_CH channels are summed into blocks of
// 2^block_log2 samples. A ring memory keeps the last n_blocks block sums per
// channel, so each channel has a running window total. When any total exceeds
// threshold_average * n_blocks * 2^block_log2, a sticky trip is raised and
// the block freezes until reset.
//
// Optional feature macro: SHIM_THRESH_INTEGRATOR_TRIP_CAPTURE_EN
//   When defined, the lowest tripping channel and its total are captured at
//   the trip. When undefined, over_chan and over_total are tied to zero.

module shim_threshold_integrator_n #(
  parameter int N_CH            = 8,
  parameter int SAMPLE_W        = 15,
  parameter int DECIM_LOG2      = 4,
  parameter int DEPTH_LOG2      = 4,
  parameter int MAX_BLOCK_LOG2  = 8,
  localparam int BSUM_W         = SAMPLE_W + MAX_BLOCK_LOG2,
  localparam int TOT_W          = BSUM_W + DEPTH_LOG2 + 1,
  localparam int BL_W           = $clog2(MAX_BLOCK_LOG2 + 1),
  localparam int CH_W           = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     enable,
  input  logic [BL_W-1:0]          block_log2,
  input  logic [DEPTH_LOG2:0]      n_blocks,
  input  logic [SAMPLE_W-1:0]      threshold_average,
  input  logic                     sample_core_done,
  input  logic [N_CH*SAMPLE_W-1:0] abs_sample_concat,
  output logic                     setup_done,
  output logic                     over_thresh,
  output logic [N_CH-1:0]          ch_over_thresh,
  output logic                     err_config,
  output logic [CH_W-1:0]          over_chan,
  output logic [TOT_W-1:0]         over_total
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int MEM_W = N_CH * BSUM_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_WAIT,
    ST_RUNNING,
    ST_TRIPPED,
    ST_ERROR
  } state_t;

  // Control and configuration registers
  state_t                     state_q, state_d;
  logic [BL_W-1:0]            bl_q, bl_d;
  logic [DEPTH_LOG2:0]        nb_q, nb_d;
  logic [SAMPLE_W-1:0]        mult_q, mult_d;
  logic [TOT_W-1:0]           mcand_q, mcand_d;
  logic [TOT_W-1:0]           max_q, max_d;

  // Sampling and block accumulation
  logic [DECIM_LOG2-1:0]      dec_q, dec_d;
  logic [MAX_BLOCK_LOG2-1:0]  scnt_q, scnt_d;
  logic [N_CH-1:0][BSUM_W-1:0] acc_q, acc_d;
  logic [N_CH-1:0][BSUM_W-1:0] blk_q, blk_d;
  logic                       blk_vld_q, blk_vld_d;

  // Ring update pipeline
  logic [N_CH-1:0][BSUM_W-1:0] new_q, new_d;
  logic                       upd_vld_q, upd_vld_d;
  logic                       use_old_q, use_old_d;
  logic [DEPTH_LOG2-1:0]      wptr_q, wptr_d;
  logic                       filled_q, filled_d;
  logic [N_CH-1:0][TOT_W-1:0] total_q, total_d;

  // Sticky status flags
  logic                       setup_done_q, setup_done_d;
  logic                       over_thresh_q, over_thresh_d;
  logic [N_CH-1:0]            ch_over_q, ch_over_d;
  logic                       err_config_q, err_config_d;

  // Ring memory and its registered read port
  logic [MEM_W-1:0]           ring_mem [DEPTH];
  logic [N_CH-1:0][BSUM_W-1:0] rd_q;
  logic                       ring_we;

  // Combinational helpers
  logic [MAX_BLOCK_LOG2:0]    blk_len;
  logic [MAX_BLOCK_LOG2-1:0]  blk_len_m1;
  logic [N_CH-1:0]            cmp_vec;
  logic                       cfg_bad;
  logic [N_CH-1:0][BSUM_W-1:0] sample_sum;
  logic [BSUM_W-1:0]          old_val;

  // Block-length terminal count, config legality check and per-channel compare
  always_comb begin
    blk_len    = (MAX_BLOCK_LOG2 + 1)'(1) << bl_q;
    blk_len_m1 = MAX_BLOCK_LOG2'(blk_len - (MAX_BLOCK_LOG2 + 1)'(1));
    cfg_bad    = (n_blocks == '0) ||
                 (n_blocks > (DEPTH_LOG2 + 1)'(DEPTH)) ||
                 (block_log2 > BL_W'(MAX_BLOCK_LOG2));
    cmp_vec    = '0;
    for (int i = 0; i < N_CH; i++) begin
      cmp_vec[i] = total_q[i] > max_q;
    end
  end

  // Main FSM: config capture, shift-add threshold setup, start and trip
  always_comb begin
    state_d       = state_q;
    bl_d          = bl_q;
    nb_d          = nb_q;
    mult_d        = mult_q;
    mcand_d       = mcand_q;
    max_d         = max_q;
    setup_done_d  = setup_done_q;
    over_thresh_d = over_thresh_q;
    ch_over_d     = ch_over_q;
    err_config_d  = err_config_q;
    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          bl_d    = block_log2;
          nb_d    = n_blocks;
          mult_d  = threshold_average;
          mcand_d = TOT_W'(n_blocks) << block_log2;
          max_d   = '0;
          if (cfg_bad) begin
            err_config_d = 1'b1;
            state_d      = ST_ERROR;
          end else begin
            state_d = ST_SETUP;
          end
        end
      end
      ST_SETUP: begin
        if (mult_q[0]) begin
          max_d = max_q + mcand_q;
        end
        mcand_d = mcand_q << 1;
        mult_d  = mult_q >> 1;
        if ((mult_q >> 1) == '0) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (sample_core_done) begin
          setup_done_d = 1'b1;
          state_d      = ST_RUNNING;
        end
      end
      ST_RUNNING: begin
        if (|cmp_vec) begin
          over_thresh_d = 1'b1;
          ch_over_d     = cmp_vec;
          state_d       = ST_TRIPPED;
        end
      end
      default: begin
      end
    endcase
  end

  // Sampling, block accumulation, ring pointer and window-total datapath
  always_comb begin
    dec_d      = dec_q;
    scnt_d     = scnt_q;
    acc_d      = acc_q;
    blk_d      = blk_q;
    blk_vld_d  = blk_vld_q;
    new_d      = new_q;
    upd_vld_d  = upd_vld_q;
    use_old_d  = use_old_q;
    wptr_d     = wptr_q;
    filled_d   = filled_q;
    total_d    = total_q;
    sample_sum = '0;
    old_val    = '0;
    if (state_q == ST_WAIT) begin
      dec_d  = '0;
      scnt_d = '0;
    end
    if (state_q == ST_RUNNING) begin
      dec_d     = dec_q + DECIM_LOG2'(1);
      blk_vld_d = 1'b0;
      if (dec_q == '0) begin
        for (int i = 0; i < N_CH; i++) begin
          sample_sum[i] = acc_q[i] +
                          BSUM_W'(abs_sample_concat[(i+1)*SAMPLE_W-1 -: SAMPLE_W]);
        end
        if (scnt_q == blk_len_m1) begin
          blk_d     = sample_sum;
          blk_vld_d = 1'b1;
          acc_d     = '0;
          scnt_d    = '0;
        end else begin
          acc_d  = sample_sum;
          scnt_d = scnt_q + MAX_BLOCK_LOG2'(1);
        end
      end
      upd_vld_d = blk_vld_q;
      if (blk_vld_q) begin
        new_d     = blk_q;
        use_old_d = filled_q;
        if ({1'b0, wptr_q} == nb_q - (DEPTH_LOG2 + 1)'(1)) begin
          wptr_d   = '0;
          filled_d = 1'b1;
        end else begin
          wptr_d = wptr_q + DEPTH_LOG2'(1);
        end
      end
      if (upd_vld_q) begin
        for (int i = 0; i < N_CH; i++) begin
          old_val    = use_old_q ? rd_q[i] : '0;
          total_d[i] = total_q[i] + TOT_W'(new_q[i]) - TOT_W'(old_val);
        end
      end
    end
  end

  // State, pipeline and flag registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      bl_q          <= '0;
      nb_q          <= '0;
      mult_q        <= '0;
      mcand_q       <= '0;
      max_q         <= '0;
      dec_q         <= '0;
      scnt_q        <= '0;
      acc_q         <= '0;
      blk_q         <= '0;
      blk_vld_q     <= 1'b0;
      new_q         <= '0;
      upd_vld_q     <= 1'b0;
      use_old_q     <= 1'b0;
      wptr_q        <= '0;
      filled_q      <= 1'b0;
      total_q       <= '0;
      setup_done_q  <= 1'b0;
      over_thresh_q <= 1'b0;
      ch_over_q     <= '0;
      err_config_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      bl_q          <= bl_d;
      nb_q          <= nb_d;
      mult_q        <= mult_d;
      mcand_q       <= mcand_d;
      max_q         <= max_d;
      dec_q         <= dec_d;
      scnt_q        <= scnt_d;
      acc_q         <= acc_d;
      blk_q         <= blk_d;
      blk_vld_q     <= blk_vld_d;
      new_q         <= new_d;
      upd_vld_q     <= upd_vld_d;
      use_old_q     <= use_old_d;
      wptr_q        <= wptr_d;
      filled_q      <= filled_d;
      total_q       <= total_d;
      setup_done_q  <= setup_done_d;
      over_thresh_q <= over_thresh_d;
      ch_over_q     <= ch_over_d;
      err_config_q  <= err_config_d;
    end
  end

  assign ring_we = blk_vld_q && (state_q == ST_RUNNING);

  // Read-first ring memory: returns the entry being overwritten in the same cycle
  always_ff @(posedge clk) begin
    if (ring_we) begin
      rd_q             <= ring_mem[wptr_q];
      ring_mem[wptr_q] <= blk_q;
    end
  end

`ifdef SHIM_THRESH_INTEGRATOR_TRIP_CAPTURE_EN
  logic [CH_W-1:0]  over_chan_q, over_chan_d, trip_chan;
  logic [TOT_W-1:0] over_total_q, over_total_d, trip_total;

  // Pick the lowest tripping channel and hold it with its total at the trip
  always_comb begin
    trip_chan    = '0;
    trip_total   = '0;
    over_chan_d  = over_chan_q;
    over_total_d = over_total_q;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (cmp_vec[i]) begin
        trip_chan  = CH_W'(i);
        trip_total = total_q[i];
      end
    end
    if ((state_q == ST_RUNNING) && (|cmp_vec)) begin
      over_chan_d  = trip_chan;
      over_total_d = trip_total;
    end
  end

  // Trip capture registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      over_chan_q  <= '0;
      over_total_q <= '0;
    end else begin
      over_chan_q  <= over_chan_d;
      over_total_q <= over_total_d;
    end
  end

  assign over_chan  = over_chan_q;
  assign over_total = over_total_q;
`else
  assign over_chan  = '0;
  assign over_total = '0;
`endif

  assign setup_done     = setup_done_q;
  assign over_thresh    = over_thresh_q;
  assign ch_over_thresh = ch_over_q;
  assign err_config     = err_config_q;

endmodule

// File: tb/tb_shim_threshold_integrator_n.sv
// tb_shim_threshold_integrator_n
// Self-checking bench for shim_threshold_integrator_n. A behavioural model
// keeps a history of per-channel block sums and derives the window totals,
// the trip cycle, the trip mask and the captured channel/total from them.

module tb_shim_threshold_integrator_n;

  localparam int N_CH           = 8;
  localparam int SAMPLE_W       = 15;
  localparam int DECIM_LOG2     = 4;
  localparam int DEPTH_LOG2     = 4;
  localparam int MAX_BLOCK_LOG2 = 8;
  localparam int BSUM_W         = SAMPLE_W + MAX_BLOCK_LOG2;
  localparam int TOT_W          = BSUM_W + DEPTH_LOG2 + 1;
  localparam int BL_W           = $clog2(MAX_BLOCK_LOG2 + 1);
  localparam int CH_W           = $clog2(N_CH);
  localparam int DECIM          = 1 << DECIM_LOG2;
  localparam int PIPE_LAT       = 4;

`ifdef SHIM_THRESH_INTEGRATOR_TRIP_CAPTURE_EN
  localparam bit CAPTURE_EN = 1'b1;
`else
  localparam bit CAPTURE_EN = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     resetn = 1'b0;
  logic                     enable = 1'b0;
  logic [BL_W-1:0]          block_log2 = '0;
  logic [DEPTH_LOG2:0]      n_blocks = '0;
  logic [SAMPLE_W-1:0]      threshold_average = '0;
  logic                     sample_core_done = 1'b0;
  logic [N_CH*SAMPLE_W-1:0] abs_sample_concat = '0;
  logic                     setup_done;
  logic                     over_thresh;
  logic [N_CH-1:0]          ch_over_thresh;
  logic                     err_config;
  logic [CH_W-1:0]          over_chan;
  logic [TOT_W-1:0]         over_total;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Model state
  longint          hist [N_CH][256];
  longint          cur_blk [N_CH];
  longint          win;
  longint          max_value;
  longint          exp_total;
  logic [N_CH-1:0] exp_mask;
  int              lowest;
  int              trip_r;
  int              obs_trip;
  int              blk_done;
  int              samples_in_blk;
  int              hot_ch  = 0;
  int              rand_hi = 100;

  shim_threshold_integrator_n #(
    .N_CH           (N_CH),
    .SAMPLE_W       (SAMPLE_W),
    .DECIM_LOG2     (DECIM_LOG2),
    .DEPTH_LOG2     (DEPTH_LOG2),
    .MAX_BLOCK_LOG2 (MAX_BLOCK_LOG2)
  ) dut (
    .clk               (clk),
    .resetn            (resetn),
    .enable            (enable),
    .block_log2        (block_log2),
    .n_blocks          (n_blocks),
    .threshold_average (threshold_average),
    .sample_core_done  (sample_core_done),
    .abs_sample_concat (abs_sample_concat),
    .setup_done        (setup_done),
    .over_thresh       (over_thresh),
    .ch_over_thresh    (ch_over_thresh),
    .err_config        (err_config),
    .over_chan         (over_chan),
    .over_total        (over_total)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    n_compared++;
    if (observed != expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input int bl, input int nb, input int thr,
                               input logic done, input logic [N_CH*SAMPLE_W-1:0] vec);
    enable            = en;
    block_log2        = BL_W'(bl);
    n_blocks          = (DEPTH_LOG2 + 1)'(nb);
    threshold_average = SAMPLE_W'(thr);
    sample_core_done  = done;
    abs_sample_concat = vec;
  endtask

  function automatic logic [N_CH*SAMPLE_W-1:0] randomVec();
    logic [N_CH*SAMPLE_W-1:0] v;
    for (int ch = 0; ch < N_CH; ch++) begin
      v[ch*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'($urandom);
    end
    return v;
  endfunction

  function automatic int sampleValue(input int mode, input int ch, input int blk);
    case (mode)
      0:       return 100;
      1:       return (ch == 3) ? 101 : 0;
      2:       return (ch == 0 && blk == 0) ? 400 : 0;
      3:       return (ch == 0 && blk == 0) ? 401 : 0;
      4:       return (ch == 3 || ch == 5) ? 101 : 0;
      default: return (ch == hot_ch) ? int'($urandom_range(0, 2 * rand_hi + 2))
                                     : int'($urandom_range(0, rand_hi));
    endcase
  endfunction

  task automatic doReset(input string name);
    resetn = 1'b0;
    applyStimulus(1'b0, 0, 0, 0, 1'b0, randomVec());
    repeat (3) @(posedge clk);
    #1;
    checkOutput({name, "_rst_setup_done"}, longint'(setup_done), 0);
    checkOutput({name, "_rst_over_thresh"}, longint'(over_thresh), 0);
    checkOutput({name, "_rst_mask"}, longint'(ch_over_thresh), 0);
    checkOutput({name, "_rst_err"}, longint'(err_config), 0);
    checkOutput({name, "_rst_over_chan"}, longint'(over_chan), 0);
    checkOutput({name, "_rst_over_total"}, longint'(over_total), 0);
    resetn = 1'b1;
  endtask

  task automatic runScenario(input string name, input int mode, input int bl, input int nb,
                             input int thr, input int n_blk, input int abort_r);
    logic [N_CH*SAMPLE_W-1:0] vec;
    int budget;
    int v;
    int r_end;
    max_value      = longint'(thr) * longint'(nb) * (longint'(1) << bl);
    trip_r         = -1;
    obs_trip       = -1;
    blk_done       = 0;
    samples_in_blk = 0;
    exp_mask       = '0;
    exp_total      = 0;
    lowest         = 0;
    for (int ch = 0; ch < N_CH; ch++) cur_blk[ch] = 0;

    doReset(name);
    applyStimulus(1'b1, bl, nb, thr, 1'b1, randomVec());
    @(posedge clk);
    #1;
    budget = 0;
    while (setup_done !== 1'b1 && budget < 64) begin
      applyStimulus(1'b0, bl, nb, thr, 1'b1, randomVec());
      @(posedge clk);
      #1;
      budget++;
    end
    if (setup_done !== 1'b1) begin
      checkOutput({name, "_setup_timeout"}, longint'(setup_done), 1);
      return;
    end

    r_end = n_blk * (1 << bl) * DECIM + 8;
    for (int r = 0; r < r_end; r++) begin
      if (r == abort_r) return;
      if (trip_r >= 0 && r > trip_r + 20) break;
      if (over_thresh === 1'b1 && obs_trip < 0) obs_trip = r;
      checkOutput({name, "_over_thresh"}, longint'(over_thresh),
                  longint'(trip_r >= 0 && r >= trip_r));
      vec = randomVec();
      if (r % DECIM == 0) begin
        for (int ch = 0; ch < N_CH; ch++) begin
          v = sampleValue(mode, ch, blk_done);
          vec[ch*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(v);
          cur_blk[ch] += longint'(v);
        end
        samples_in_blk++;
        if (samples_in_blk == (1 << bl)) begin
          for (int ch = 0; ch < N_CH; ch++) begin
            hist[ch][blk_done] = cur_blk[ch];
            cur_blk[ch] = 0;
          end
          blk_done++;
          samples_in_blk = 0;
          if (trip_r < 0) begin
            for (int ch = 0; ch < N_CH; ch++) begin
              win = 0;
              for (int k = (blk_done > nb) ? blk_done - nb : 0; k < blk_done; k++) begin
                win += hist[ch][k];
              end
              if (win > max_value) begin
                if (exp_mask == '0) begin
                  lowest    = ch;
                  exp_total = win;
                end
                exp_mask[ch] = 1'b1;
              end
            end
            if (exp_mask != '0) trip_r = r + PIPE_LAT;
          end
        end
      end
      if (r == 5) applyStimulus(1'b1, 0, 1, 0, 1'b1, vec);
      else        applyStimulus(1'b0, bl, nb, thr, 1'b1, vec);
      @(posedge clk);
      #1;
    end

    checkOutput({name, "_trip_cycle"}, longint'(obs_trip), longint'(trip_r));
    checkOutput({name, "_mask"}, longint'(ch_over_thresh), longint'(exp_mask));
    checkOutput({name, "_over_chan"}, longint'(over_chan),
                (CAPTURE_EN && trip_r >= 0) ? longint'(lowest) : 0);
    checkOutput({name, "_over_total"}, longint'(over_total),
                (CAPTURE_EN && trip_r >= 0) ? exp_total : 0);
    checkOutput({name, "_setup_done"}, longint'(setup_done), 1);
    checkOutput({name, "_err_config"}, longint'(err_config), 0);
  endtask

  task automatic runErrorCase(input string name, input int bl, input int nb, input int thr);
    doReset(name);
    applyStimulus(1'b1, bl, nb, thr, 1'b1, randomVec());
    @(posedge clk);
    #1;
    checkOutput({name, "_err_next_cycle"}, longint'(err_config), 1);
    checkOutput({name, "_setup_done_now"}, longint'(setup_done), 0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(i[0], 2, 4, 100, 1'b1, randomVec());
      @(posedge clk);
      #1;
    end
    checkOutput({name, "_err_sticky"}, longint'(err_config), 1);
    checkOutput({name, "_setup_done_later"}, longint'(setup_done), 0);
    checkOutput({name, "_over_thresh"}, longint'(over_thresh), 0);
  endtask

  initial begin
    runScenario("const100", 0, 2, 4, 100, 100, -1);
    runScenario("ch3_101", 1, 2, 4, 100, 8, -1);
    runScenario("ch0_400", 2, 2, 4, 100, 8, -1);
    runScenario("ch0_401", 3, 2, 4, 100, 8, -1);
    runScenario("ch3_abort", 1, 2, 4, 100, 8, 150);
    runScenario("ch3_rerun", 1, 2, 4, 100, 8, -1);
    runScenario("ch35_101", 4, 2, 4, 100, 8, -1);
    runErrorCase("nb0", 2, 0, 100);
    runErrorCase("nb17", 2, 17, 100);
    runErrorCase("bl9", 9, 4, 100);
    hot_ch  = 6;
    rand_hi = 60;
    runScenario("nb16_bl0", 5, 0, 16, 60, 40, -1);
    hot_ch  = 1;
    rand_hi = 90;
    runScenario("nb1_bl1", 5, 1, 1, 90, 30, -1);
    for (int t = 0; t < 5; t++) begin
      int thr_r;
      int nb_r;
      int bl_r;
      thr_r   = int'($urandom_range(20, 200));
      nb_r    = int'($urandom_range(1, 16));
      bl_r    = int'($urandom_range(0, 2));
      hot_ch  = int'($urandom_range(0, N_CH - 1));
      rand_hi = thr_r;
      runScenario($sformatf("rand%0d", t), 5, bl_r, nb_r, thr_r, 40, -1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
